// File: rtl/ariane_pkg.sv
// Shared types for the misaligned-load merge unit: access size encoding and
// the request record captured in the first pipeline stage.
package ariane_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } size_e;

  // The request record is sized for the widest legal configuration
  // (XLEN=64, 3 offset bits, up to 8 id bits); narrower units zero-extend.
  localparam int unsigned MAX_XLEN  = 64;
  localparam int unsigned MAX_OFF_W = 3;
  localparam int unsigned MAX_TID_W = 8;

  typedef struct packed {
    logic [MAX_XLEN-1:0]  lo;
    logic [MAX_XLEN-1:0]  hi;
    logic [MAX_OFF_W-1:0] offset;
    size_e                size;
    logic                 sgn;
    logic [MAX_TID_W-1:0] tid;
  } merge_req_t;

endpackage

// File: rtl/merge_fifo.sv
// Result buffer: DEPTH-entry FIFO with modulo-DEPTH pointers. Storage is not
// reset; only pointers and count are cleared by rst/flush.
module merge_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 35
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Entry storage, written on push only.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wrap_inc(wptr);
      if (pop)  rptr <= wrap_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign empty = (count == '0);

endmodule

// File: rtl/misalign_merge_unit.sv
// Misaligned load merge: captures {hi,lo} words, extracts 2^size bytes at the
// byte offset, sign/zero-extends and queues the result with its id.
module misalign_merge_unit
  import ariane_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [XLEN-1:0]               lo_word_i,
  input  logic [XLEN-1:0]               hi_word_i,
  input  logic [$clog2(XLEN/8)-1:0]     offset_i,
  input  logic [1:0]                    size_i,
  input  logic                          signed_i,
  input  logic [TRANS_ID_BITS-1:0]      trans_id_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [XLEN-1:0]               result_o,
  output logic [TRANS_ID_BITS-1:0]      trans_id_o
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = XLEN + TRANS_ID_BITS;

  merge_req_t                  req_p1;
  logic                        vld_p1;
  logic [2*MAX_XLEN-1:0]       cat_p1;
  logic [2*MAX_XLEN-1:0]       shifted_p1;
  logic [XLEN-1:0]             result_p1;
  logic [ENTRY_W-1:0]          head;
  logic [CNT_W-1:0]            fifo_count;
  logic                        fifo_empty;
  logic                        accept;
  logic                        pop;
  logic                        unused_bits;

  // Keep the low 2^size bytes of the shifted window and extend to XLEN.
  // On a 32-bit unit a dword request degrades to a word.
  function automatic logic [XLEN-1:0] extend_fn(input logic [63:0] w,
                                                input size_e sz,
                                                input logic sgn);
    logic [63:0] r;
    size_e       eff;
    eff = (XLEN == 32 && sz == DWORD) ? WORD : sz;
    case (eff)
      BYTE:    r = {{56{sgn & w[7]}},  w[7:0]};
      HALF:    r = {{48{sgn & w[15]}}, w[15:0]};
      WORD:    r = {{32{sgn & w[31]}}, w[31:0]};
      default: r = w;
    endcase
    return r[XLEN-1:0];
  endfunction

  // Credit rule: only registered state feeds ready_o.
  assign ready_o = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, vld_p1}) < (CNT_W+1)'(DEPTH);
  assign accept  = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  // Stage 1 control: reset and flush kill the in-flight request.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) vld_p1 <= 1'b0;
    else                  vld_p1 <= accept;
  end

  // Stage 1 data capture, unreset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_p1.lo     <= MAX_XLEN'(lo_word_i);
      req_p1.hi     <= MAX_XLEN'(hi_word_i);
      req_p1.offset <= MAX_OFF_W'(offset_i);
      req_p1.size   <= size_e'(size_i);
      req_p1.sgn    <= signed_i;
      req_p1.tid    <= MAX_TID_W'(trans_id_i);
    end
  end

  // ---- stage 2: shift/extend, then push into the result FIFO ----
  always_comb begin
    cat_p1     = (2*MAX_XLEN)'({req_p1.hi[XLEN-1:0], req_p1.lo[XLEN-1:0]});
    shifted_p1 = cat_p1 >> {req_p1.offset, 3'b000};
    result_p1  = extend_fn(shifted_p1[63:0], req_p1.size, req_p1.sgn);
  end

  // Bits only meaningful in wider configurations are folded here.
  assign unused_bits = ^{req_p1, shifted_p1};

  merge_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (flush_i),
    .push  (vld_p1 && !flush_i),
    .wdata ({result_p1, req_p1.tid[TRANS_ID_BITS-1:0]}),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Outputs are forced to zero while empty so unreset storage never leaks.
  assign valid_o    = !fifo_empty;
  assign result_o   = valid_o ? head[ENTRY_W-1:TRANS_ID_BITS] : '0;
  assign trans_id_o = valid_o ? head[TRANS_ID_BITS-1:0] : '0;

endmodule

// File: tb/tb_misalign_merge_unit.sv
// Directed bench for misalign_merge_unit (XLEN=32, DEPTH=2, 3-bit ids).
module tb_misalign_merge_unit;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_o, signed_i, valid_o, ready_i;
  logic [31:0] lo_word_i, hi_word_i, result_o;
  logic [1:0]  offset_i, size_i;
  logic [2:0]  trans_id_i, trans_id_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  misalign_merge_unit #(.XLEN(32), .DEPTH(2), .TRANS_ID_BITS(3)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .lo_word_i  (lo_word_i),
    .hi_word_i  (hi_word_i),
    .offset_i   (offset_i),
    .size_i     (size_i),
    .signed_i   (signed_i),
    .trans_id_i (trans_id_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .trans_id_o (trans_id_o)
  );

  task automatic drive_req(input logic [31:0] lo, input logic [31:0] hi,
                           input logic [1:0] off, input logic [1:0] sz,
                           input logic sg, input logic [2:0] id);
    valid_i = 1'b1; lo_word_i = lo; hi_word_i = hi;
    offset_i = off; size_i = sz; signed_i = sg; trans_id_i = id;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    lo_word_i = '0; hi_word_i = '0; offset_i = '0; size_i = '0;
    signed_i = 1'b0; trans_id_i = '0;
    repeat (2) step();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    tests++; if (result_o !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 0", result_o); end
    tests++; if (trans_id_o !== 3'd0) begin fails++; $display("FAIL reset_id: got %0d want 0", trans_id_o); end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_merge();
    logic [31:0] lo_t  [7] = '{32'h44332211, 32'h44332211, 32'h44332211, 32'h44332211,
                               32'h44802211, 32'h44332211, 32'h44802211};
    logic [31:0] hi_t  [7] = '{32'h88776655, 32'h887766F5, 32'h887766F5, 32'h88776655,
                               32'h00000000, 32'h88776655, 32'h00000000};
    logic [1:0]  off_t [7] = '{2'd1, 2'd3, 2'd3, 2'd0, 2'd2, 2'd1, 2'd2};
    logic [1:0]  sz_t  [7] = '{2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd3, 2'd0};
    logic        sg_t  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] exp_t [7] = '{32'h55443322, 32'hFFFFF544, 32'h0000F544, 32'h44332211,
                               32'hFFFFFF80, 32'h55443322, 32'h00000080};
    ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive_req(lo_t[i], hi_t[i], off_t[i], sz_t[i], sg_t[i], 3'(i));
      step();
      valid_i = 1'b0;
      tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL merge%0d_early_valid: got %b want 0", i, valid_o); end
      step();
      tests++; if (valid_o !== 1'b1) begin fails++; $display("FAIL merge%0d_valid: got %b want 1", i, valid_o); end
      tests++; if (result_o !== exp_t[i]) begin fails++; $display("FAIL merge%0d_result: got %h want %h", i, result_o, exp_t[i]); end
      tests++; if (trans_id_o !== 3'(i)) begin fails++; $display("FAIL merge%0d_id: got %0d want %0d", i, trans_id_o, i); end
      step();
    end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    drive_req(32'h11111111, 32'h0, 2'd0, 2'd2, 1'b0, 3'd1);
    step();
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL bp_ready_after1: got %b want 1", ready_o); end
    trans_id_i = 3'd2; lo_word_i = 32'h22222222;
    step();
    tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready_after2: got %b want 0", ready_o); end
    trans_id_i = 3'd3; lo_word_i = 32'h33333333;
    step();
    tests++; if (valid_o !== 1'b1 || trans_id_o !== 3'd1) begin fails++; $display("FAIL bp_head: got v=%b id=%0d want v=1 id=1", valid_o, trans_id_o); end
    step();
    tests++; if (result_o !== 32'h11111111 || trans_id_o !== 3'd1 || ready_o !== 1'b0) begin
      fails++; $display("FAIL bp_hold: got %h id=%0d rdy=%b want 11111111 id=1 rdy=0", result_o, trans_id_o, ready_o); end
    ready_i = 1'b1;
    step();
    tests++; if (trans_id_o !== 3'd2 || result_o !== 32'h22222222 || ready_o !== 1'b1) begin
      fails++; $display("FAIL bp_second: got id=%0d %h rdy=%b want id=2 22222222 rdy=1", trans_id_o, result_o, ready_o); end
    step();
    valid_i = 1'b0;
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL bp_gap: got %b want 0", valid_o); end
    step();
    tests++; if (valid_o !== 1'b1 || trans_id_o !== 3'd3 || result_o !== 32'h33333333) begin
      fails++; $display("FAIL bp_third: got v=%b id=%0d %h want v=1 id=3 33333333", valid_o, trans_id_o, result_o); end
    step();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL bp_drained: got %b want 0", valid_o); end
  endtask

  task automatic test_flush();
    ready_i = 1'b0;
    drive_req(32'h44444444, 32'h0, 2'd0, 2'd2, 1'b0, 3'd4);
    step();
    drive_req(32'h55555555, 32'h0, 2'd0, 2'd2, 1'b0, 3'd5);
    step();
    drive_req(32'h66666666, 32'h0, 2'd0, 2'd2, 1'b0, 3'd6);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", valid_o); end
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b want 1", ready_o); end
    repeat (2) step();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL flush_dropped: got v=%b id=%0d want v=0", valid_o, trans_id_o); end
    drive_req(32'h12345678, 32'h0, 2'd0, 2'd2, 1'b0, 3'd7);
    step();
    valid_i = 1'b0;
    step();
    tests++; if (valid_o !== 1'b1 || trans_id_o !== 3'd7 || result_o !== 32'h12345678) begin
      fails++; $display("FAIL flush_after: got v=%b id=%0d %h want v=1 id=7 12345678", valid_o, trans_id_o, result_o); end
    step();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL flush_only_one: got v=%b id=%0d want v=0", valid_o, trans_id_o); end
  endtask

  task automatic test_reset_midstream();
    ready_i = 1'b0;
    drive_req(32'hAAAA0001, 32'h0, 2'd0, 2'd2, 1'b0, 3'd1);
    step();
    trans_id_i = 3'd2;
    step();
    trans_id_i = 3'd3;
    step();
    tests++; if (ready_o !== 1'b0 || valid_o !== 1'b1) begin fails++; $display("FAIL rstm_full: got rdy=%b v=%b want rdy=0 v=1", ready_o, valid_o); end
    rst_i = 1'b1; ready_i = 1'b1; flush_i = 1'b1;
    step();
    rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    tests++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin fails++; $display("FAIL rstm_state: got v=%b rdy=%b want v=0 rdy=1", valid_o, ready_o); end
    tests++; if (result_o !== 32'h0 || trans_id_o !== 3'd0) begin fails++; $display("FAIL rstm_outputs: got %h id=%0d want 0 id=0", result_o, trans_id_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rstm_stale%0d: got v=%b id=%0d want v=0", i, valid_o, trans_id_o); end
    end
    drive_req(32'hDEADBEEF, 32'h0, 2'd0, 2'd2, 1'b0, 3'd5);
    step();
    valid_i = 1'b0;
    step();
    tests++; if (valid_o !== 1'b1 || trans_id_o !== 3'd5 || result_o !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rstm_resume: got v=%b id=%0d %h want v=1 id=5 deadbeef", valid_o, trans_id_o, result_o); end
    step();
  endtask

  task automatic test_back_to_back();
    int  sent = 0;
    int  got  = 0;
    logic acc;
    ready_i = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (sent < 4) drive_req(32'hCAFE0000 + 32'(sent), 32'h0, 2'd0, 2'd2, 1'b0, 3'(sent));
      else valid_i = 1'b0;
      acc = valid_i && ready_o;
      if (valid_o && ready_i) begin
        tests++;
        if (trans_id_o !== 3'(got) || result_o !== 32'hCAFE0000 + 32'(got)) begin
          fails++; $display("FAIL b2b_order%0d: got id=%0d %h want id=%0d %h", got, trans_id_o, result_o, got, 32'hCAFE0000 + 32'(got));
        end
        got++;
      end
      step();
      if (acc) sent++;
    end
    valid_i = 1'b0;
    tests++; if (got !== 4) begin fails++; $display("FAIL b2b_count: got %0d results want 4", got); end
  endtask

  initial begin
    test_reset();
    test_merge();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
